dm_responder: RTL
=================

DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 6, number of word-address bits (64 x 32-bit words).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait-state count between request capture and response (legal 0..15).
REQ-003 SHALL have port clk  input  1  single clock, all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port R_Enable  input  1  read request, sampled only in IDLE.
REQ-006 SHALL have port W_Enable  input  1  write request, sampled only in IDLE.
REQ-007 SHALL have port Addr  input  32  byte address, sampled with the request.
REQ-008 SHALL have port W_data  input  32  write data, sampled with the request.
REQ-009 SHALL have port R_data  output  32  read data, valid only while Ready=1.
REQ-010 SHALL have port Ready  output  1  one-cycle response pulse ending each accepted request.
REQ-011 SHALL have port Busy  output  1  high from the cycle after acceptance through the Ready cycle inclusive.
REQ-012 SHALL have port Err  output  1  error status, valid only while Ready=1.

Function
REQ-013 SHALL implement states IDLE, WAIT, RESP; all outputs registered or decoded from state, no combinational input-to-output path.
REQ-014 In IDLE, R_Enable|W_Enable high at a rising edge SHALL capture Addr, W_data and operation type; go to WAIT if WAIT_CYCLES>0, else directly to RESP.
REQ-015 WAIT SHALL last exactly WAIT_CYCLES cycles, counted by a down-counter loaded at capture, then go to RESP.
REQ-016 RESP SHALL last exactly one cycle with Ready=1, then return to IDLE.
REQ-017 Latency: request sampled at edge 0 -> Ready high in cycle WAIT_CYCLES+1; throughput one access per WAIT_CYCLES+2 cycles.
REQ-018 Requests in WAIT or RESP SHALL be ignored, not queued; the initiator holds them until sampled in IDLE.
REQ-019 Valid read: R_data SHALL equal mem[Addr[DEPTH_LOG2+1:2]] during RESP, with Err=0.
REQ-020 Valid write: mem[Addr[DEPTH_LOG2+1:2]] SHALL be updated with captured W_data at the rising edge ending RESP; R_data=0 during that Ready.
REQ-021 Error cases: Addr[1:0]!=0; any of Addr[31:DEPTH_LOG2+2]!=0; R_Enable and W_Enable both high.
REQ-022 On error SHALL give the same latency with Err=1, R_data=0 and no memory update.
REQ-023 Outside RESP, Ready=0, Err=0, R_data=0.
REQ-024 Address arithmetic SHALL be word-indexed, with no wrap-around: out-of-range addresses SHALL report errors, never alias.
REQ-025 Read of a word written by the immediately preceding completed write SHALL return the new data.

Reset
REQ-026 reset high at a rising edge SHALL force IDLE, clear the wait counter and captured request, and drive Ready=0, Busy=0, Err=0, R_data=0 from the next cycle.
REQ-027 reset SHALL take priority over every request and state transition; reset in WAIT or RESP SHALL abort the access and discard a pending write, leaving memory unchanged.
REQ-028 Memory contents SHALL NOT be cleared by reset; contents are undefined until written.
REQ-029 The first request SHALL be sampleable at the first rising edge with reset low.

Verification
REQ-030 WAIT_CYCLES=2: write Addr=0x08, W_data=0xDEADBEEF, then read Addr=0x08 -> write Ready in cycle 3 with Err=0; read Ready in cycle 3 after its capture with R_data=0xDEADBEEF, Busy high for 3 cycles each.
REQ-031 Misaligned read Addr=0x0A -> Ready with Err=1, R_data=0; write Addr=0x102 (out of range) -> Err=1, then a read of word 0 -> unchanged.
REQ-032 R_Enable=W_Enable=1 at Addr=0x04 -> Err=1, and a subsequent read of 0x04 returns its prior value.
REQ-033 Write 0x1234 to 0x10, then assert reset during WAIT of a write 0x5555 to 0x10 -> outputs 0 next cycle; a read of 0x10 returns 0x1234.
REQ-034 WAIT_CYCLES=0: back-to-back held requests -> Ready every second cycle, with Busy and Ready coincident; a request held during Busy is accepted exactly once per IDLE visit.
REQ-035 Write 0xFFFFFFFF to 0xFC (last word) and 0x0 to 0x00 -> both read back correctly, and no aliasing occurs.

Source files
------------

// File: rtl/dm_responder.sv
// Wait-state data-memory responder: captures one read/write request in IDLE,
// holds it for WAIT_CYCLES, then answers with a one-cycle Ready pulse.
module dm_responder #(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        R_Enable,
  input  logic        W_Enable,
  input  logic [31:0] Addr,
  input  logic [31:0] W_data,
  output logic [31:0] R_data,
  output logic        Ready,
  output logic        Busy,
  output logic        Err
);

  localparam int unsigned DEPTH    = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W    = 4;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned IDX_LSB  = 2;
  localparam int unsigned ADDR_TOP = DEPTH_LOG2 + IDX_LSB;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0]   cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0]       cap_wdata_q, cap_wdata_d;
  logic                    cap_write_q, cap_write_d;
  logic                    cap_err_q, cap_err_d;

  logic [DATA_W-1:0]       rdata_d;
  logic                    ready_d, busy_d, err_d;

  logic                    req_c;
  logic                    req_err_c;
  logic [DEPTH_LOG2-1:0]   req_idx_c;

  logic [DATA_W-1:0]       mem [DEPTH];

  // Request decode: misaligned, beyond the array, or both enables at once.
  always_comb begin
    req_c     = R_Enable | W_Enable;
    req_idx_c = Addr[ADDR_TOP-1:IDX_LSB];
    req_err_c = (Addr[IDX_LSB-1:0] != '0)
              || ((Addr >> ADDR_TOP) != '0)
              || (R_Enable & W_Enable);
  end

  // State register, captured request and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      cap_idx_q   <= '0;
      cap_wdata_q <= '0;
      cap_write_q <= 1'b0;
      cap_err_q   <= 1'b0;
      R_data      <= '0;
      Ready       <= 1'b0;
      Busy        <= 1'b0;
      Err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cap_idx_q   <= cap_idx_d;
      cap_wdata_q <= cap_wdata_d;
      cap_write_q <= cap_write_d;
      cap_err_q   <= cap_err_d;
      R_data      <= rdata_d;
      Ready       <= ready_d;
      Busy        <= busy_d;
      Err         <= err_d;
    end
  end

  // Next state; requests outside IDLE are ignored rather than queued.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cap_idx_d   = cap_idx_q;
    cap_wdata_d = cap_wdata_q;
    cap_write_d = cap_write_q;
    cap_err_d   = cap_err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          cap_idx_d   = req_idx_c;
          cap_wdata_d = W_data;
          cap_write_d = W_Enable;
          cap_err_d   = req_err_c;
          if (WAIT_CYCLES == 0) begin
            state_d = ST_RESP;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES);
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the coming cycle, derived from the next state.
  // The array is read on entry to RESP; any earlier write has already landed.
  always_comb begin
    ready_d = 1'b0;
    busy_d  = 1'b0;
    err_d   = 1'b0;
    rdata_d = '0;
    if (state_d != ST_IDLE) begin
      busy_d = 1'b1;
    end
    if (state_d == ST_RESP) begin
      ready_d = 1'b1;
      err_d   = cap_err_d;
      if (!cap_err_d && !cap_write_d) begin
        rdata_d = mem[cap_idx_d];
      end
    end
  end

  // Write commits on the edge that ends RESP; reset aborts it. Not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && (state_q == ST_RESP) && cap_write_q && !cap_err_q) begin
      mem[cap_idx_q] <= cap_wdata_q;
    end
  end

endmodule
